// File: rtl/digit_serial_sub32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : digit_serial_sub32_pkg
// Purpose  : Shared defaults and FSM state type for the digit-serial subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package digit_serial_sub32_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_BLK   = 4;
    localparam int NBLK      = DEF_WIDTH / DEF_BLK;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : digit_serial_sub32_pkg
`default_nettype wire

// File: rtl/digit_serial_sub32_sub_block.sv
`default_nettype none
// ============================================================================
// Module   : sub_block
// Purpose  : BLK-bit ripple-carry adder slice used once per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sub_block #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] s,
    output logic           cout
);

    logic [BLK:0] w_c;

    always_comb begin
        s      = '0;
        w_c    = '0;
        w_c[0] = cin;
        for (int i = 0; i < BLK; i++) begin
            s[i]     = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
        end
    end

    assign cout = w_c[BLK];

endmodule : sub_block
`default_nettype wire

// File: rtl/digit_serial_sub32.sv
`default_nettype none
// ============================================================================
// Module   : digit_serial_sub32
// Purpose  : Signed A-B computed BLK bits per cycle, with overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module digit_serial_sub32
    import digit_serial_sub32_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLK   = DEF_BLK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   DIFF,
    output logic             OVF
);

    localparam int L_NBLK = WIDTH / BLK;
    localparam int KW     = (L_NBLK > 1) ? $clog2(L_NBLK) : 1;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b_inv;
    logic [KW-1:0]    r_k;
    logic             r_carry;
    logic [WIDTH:0]   r_diff;
    logic             r_ovf;

    logic [BLK-1:0]   w_a_blk;
    logic [BLK-1:0]   w_b_blk;
    logic [BLK-1:0]   w_s;
    logic             w_cout;
    logic             w_last;
    logic             w_msb;

    assign w_last = (r_k == KW'(L_NBLK - 1));

    // Borrow chain is realised as A + ~B + 1, so carry starts at 1.
    assign w_msb  = r_a[WIDTH-1] ^ r_b_inv[WIDTH-1] ^ w_cout;

    always_comb begin
        w_a_blk = '0;
        w_b_blk = '0;
        for (int j = 0; j < L_NBLK; j++) begin
            if (r_k == KW'(j)) begin
                w_a_blk = r_a[j*BLK +: BLK];
                w_b_blk = r_b_inv[j*BLK +: BLK];
            end
        end
    end

    sub_block #(
        .BLK (BLK)
    ) u_sub_block (
        .a    (w_a_blk),
        .b    (w_b_blk),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default:                w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b_inv <= '0;
            r_k     <= '0;
            r_carry <= 1'b0;
            r_diff  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (r_state == IDLE && in_valid) begin
                r_a     <= A;
                r_b_inv <= ~B;
                r_k     <= '0;
                r_carry <= 1'b1;
            end else if (r_state == RUN) begin
                for (int j = 0; j < L_NBLK; j++) begin
                    if (r_k == KW'(j)) begin
                        r_diff[j*BLK +: BLK] <= w_s;
                    end
                end
                r_carry <= w_cout;
                if (w_last) begin
                    r_k           <= '0;
                    r_diff[WIDTH] <= w_msb;
                    r_ovf         <= w_msb ^ w_s[BLK-1];
                end else begin
                    r_k <= r_k + KW'(1);
                end
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign DIFF      = r_diff;
    assign OVF       = r_ovf;

endmodule : digit_serial_sub32
`default_nettype wire

// File: doc/digit_serial_sub32.md
DIGIT_SERIAL_SUB32 -- requirements
Module: digit_serial_sub32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter BLK, default 4, bits processed per cycle; WIDTH SHALL be a multiple of BLK.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand pair A,B offered.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 A  input  WIDTH  signed minuend.
REQ-008 B  input  WIDTH  signed subtrahend.
REQ-009 out_valid  output  1  DIFF/OVF hold a finished result.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 DIFF  output  WIDTH+1  exact signed difference A-B, sign-extended.
REQ-012 OVF  output  1  1 when A-B does not fit in signed WIDTH bits.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE).
REQ-015 IDLE: on in_valid&&in_ready at an edge, SHALL capture A, B (B stored inverted), set block index 0, borrow-chain carry 1, go RUN.
REQ-016 RUN: each edge SHALL add block k of A, ~B and carry, write DIFF[BLK*k+BLK-1:BLK*k], store carry-out, increment k.
REQ-017 On the edge processing the last block (k=WIDTH/BLK-1), SHALL set DIFF[WIDTH]=A[WIDTH-1]^~B[WIDTH-1]^carry-out, set OVF=DIFF[WIDTH]^DIFF[WIDTH-1], go DONE.
REQ-018 Latency: accept at edge N -> out_valid high after edge N+WIDTH/BLK (N+8 at defaults).
REQ-019 DONE: DIFF, OVF SHALL hold stable until out_valid&&out_ready at an edge, then go IDLE.
REQ-020 in_valid during RUN/DONE SHALL be ignored; changes on A/B after capture SHALL NOT affect the result.
REQ-021 out_ready while out_valid=0 SHALL be ignored.
REQ-022 No back-to-back overlap: next accept earliest one edge after output handshake.
REQ-023 DIFF SHALL be undefined-free: unwritten blocks during RUN hold the previous value, driven from registers only.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, DIFF=0, OVF=0, block index 0, carry 0, out_valid 0, in_ready 1 after deassert.
REQ-025 Reset during RUN or DONE SHALL abandon the operation with no output handshake.

Structure
REQ-026 Shared package SHALL hold WIDTH/BLK defaults, NBLK=WIDTH/BLK, and the state enum {IDLE,RUN,DONE}.
REQ-027 Per-cycle block arithmetic SHALL be a sub-module sub_block (BLK-bit ripple adder: a, b, cin -> s, cout), instantiated once.

Verification
REQ-028 A=5, B=3 accepted at edge 0 -> out_valid after edge 8, DIFF=33'h0_0000_0002, OVF=0.
REQ-029 A=32'h8000_0000, B=1 -> DIFF=33'h1_7FFF_FFFF, OVF=1.
REQ-030 A=0, B=32'h8000_0000 -> DIFF=33'h0_8000_0000, OVF=1; A=B=32'hFFFF_FFFF -> DIFF=0, OVF=0.
REQ-031 Backpressure: out_ready low 5 cycles after out_valid -> DIFF/OVF stable, in_ready=0, in_valid ignored; out_ready high -> IDLE next edge.
REQ-032 rst_n pulsed low during RUN at block 4 -> out_valid=0, DIFF=0 at once; new operation 7-2 afterwards yields DIFF=5 after 8 cycles.
REQ-033 Random 10k signed pairs with random valid/ready stalls -> DIFF equals 33-bit A-B, OVF matches reference model.
